// File: rtl/alu_arbiter.sv
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Two-port front end for one shared combinational ALU. It grants a
//             requester, runs the ALU for one cycle and returns the result.
//  Config   : ALU_ARB_RR_EN defined   -> round-robin on simultaneous requests
//             ALU_ARB_RR_EN undefined -> fixed priority, port 0 wins
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_ctr,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_ctr,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctr,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_armed;
  logic             r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_ctr;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_err;
  logic             r_rsp0_valid;
  logic             r_rsp1_valid;
  logic             w_grant_id;
  logic             w_accept;
  logic             w_illegal;

`ifdef ALU_ARB_RR_EN
  logic             r_last;
`endif

  always_comb begin
    w_grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
      w_grant_id = ~r_last;
`else
      w_grant_id = 1'b0;
`endif
    end else if (req1_valid) begin
      w_grant_id = 1'b1;
    end
  end

  // r_armed holds off acceptance until the first clock edge after reset release
  assign w_accept   = (r_state == ST_IDLE) && r_armed && (req0_valid || req1_valid);
  assign req0_ready = w_accept && !w_grant_id;
  assign req1_ready = w_accept &&  w_grant_id;

  assign w_illegal  = (r_ctr[3:2] == 2'b11);

  assign alu_a      = (r_state != ST_IDLE) ? r_a   : '0;
  assign alu_b      = (r_state != ST_IDLE) ? r_b   : '0;
  assign alu_ctr    = (r_state != ST_IDLE) ? r_ctr : 4'b0000;

  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_err    = r_rsp_err;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_armed      <= 1'b0;
      r_id         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_ctr        <= 4'b0000;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
`ifdef ALU_ARB_RR_EN
      r_last       <= 1'b1;
`endif
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_id  <= w_grant_id;
            r_a   <= w_grant_id ? req1_a   : req0_a;
            r_b   <= w_grant_id ? req1_b   : req0_b;
            r_ctr <= w_grant_id ? req1_ctr : req0_ctr;
`ifdef ALU_ARB_RR_EN
            r_last <= w_grant_id;
`endif
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Illegal opcodes never forward the ALU's answer
          if (w_illegal) begin
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b1;
            r_rsp_err    <= 1'b1;
          end else begin
            r_rsp_result <= alu_result;
            r_rsp_zero   <= alu_zero;
            r_rsp_err    <= 1'b0;
          end
          r_rsp0_valid <= ~r_id;
          r_rsp1_valid <=  r_id;
          r_state      <= ST_DONE;
        end
        ST_DONE: begin
          r_rsp0_valid <= 1'b0;
          r_rsp1_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_rsp0_valid <= 1'b0;
          r_rsp1_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Self-checking bench for alu_arbiter with a behavioural ALU stub
//             and a transaction-timeline reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_ctr, req1_ctr;
  logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp_result, alu_a, alu_b, alu_result;
  logic         rsp_zero, rsp_err, alu_zero;
  logic [3:0]   alu_ctr;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ctr(req0_ctr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ctr(req1_ctr), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Shared ALU stub: shifts move b by a[4:0]
  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    logic signed [W-1:0] sb;
    sb = b;
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a | b);
      4'd6:    return {31'd0, a < b};
      4'd7:    return b << a[4:0];
      4'd8:    return b >> a[4:0];
      4'd9:    return {31'd0, $signed(a) < $signed(b)};
      4'd10:   return sb >>> a[4:0];
      4'd11:   return {b[15:0], 16'h0000};
      default: return '0;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_a, alu_b, alu_ctr);
    alu_zero   = (alu_result == '0);
  end

  // Expected {result, zero, err} seen by a requester
  function automatic logic [W+1:0] exp_rsp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    logic [W-1:0] r;
    if (c >= 4'd12) return {{W{1'b0}}, 1'b1, 1'b1};
    r = alu_fn(a, b, c);
    return {r, (r == '0), 1'b0};
  endfunction

  int checks = 0, failures = 0, cyc = 0;

  // Reference model: an op accepted in cycle c runs the ALU in c+1..c+2,
  // answers in c+2, and the next acceptance may happen in c+3.
  int           free_at;
  bit           m_last;
  bit           op_on;
  int           op_cyc;
  bit           op_id;
  logic [W-1:0] op_a, op_b;
  logic [3:0]   op_ctr;
  logic [W-1:0] e_res;
  logic         e_zero, e_err;
  bit           acc0, acc1;
  logic         s_rdy0, s_rdy1, s_rv0, s_rv1, s_zero, s_err;
  logic [W-1:0] s_res;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    op_on  = 1'b0;
    m_last = 1'b1;
    e_res  = '0;
    e_zero = 1'b0;
    e_err  = 1'b0;
    acc0   = 1'b0;
    acc1   = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rdy0"}, req0_ready, 0);
    chk({tag, "_rdy1"}, req1_ready, 0);
    chk({tag, "_rv0"},  rsp0_valid, 0);
    chk({tag, "_rv1"},  rsp1_valid, 0);
    chk({tag, "_res"},  rsp_result, 0);
    chk({tag, "_zero"}, rsp_zero, 0);
    chk({tag, "_err"},  rsp_err, 0);
    chk({tag, "_alua"}, alu_a, 0);
    chk({tag, "_alub"}, alu_b, 0);
    chk({tag, "_aluc"}, alu_ctr, 0);
  endtask

  // Caller drives inputs just after a rising edge; this checks the cycle.
  task automatic step();
    logic g, er0, er1, ev0, ev1;
    logic [W-1:0] ea, eb;
    logic [3:0] ec;
    @(negedge clk);
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
      g = ~m_last;
`else
      g = 1'b0;
`endif
    end else begin
      g = req1_valid;
    end
    er0 = (cyc >= free_at) && (req0_valid || req1_valid) && !g;
    er1 = (cyc >= free_at) && (req0_valid || req1_valid) &&  g;
    ea = '0; eb = '0; ec = 4'd0; ev0 = 1'b0; ev1 = 1'b0;
    if (op_on && (cyc == op_cyc + 1 || cyc == op_cyc + 2)) begin
      ea = op_a; eb = op_b; ec = op_ctr;
    end
    if (op_on && cyc == op_cyc + 2) begin
      {e_res, e_zero, e_err} = exp_rsp(op_a, op_b, op_ctr);
      ev0 = !op_id;
      ev1 = op_id;
    end
    chk("ready0", req0_ready, er0);
    chk("ready1", req1_ready, er1);
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
    chk("alu_ctr", alu_ctr, ec);
    chk("rsp0_valid", rsp0_valid, ev0);
    chk("rsp1_valid", rsp1_valid, ev1);
    chk("rsp_result", rsp_result, e_res);
    chk("rsp_zero", rsp_zero, e_zero);
    chk("rsp_err", rsp_err, e_err);
    s_rdy0 = req0_ready; s_rdy1 = req1_ready;
    s_rv0 = rsp0_valid; s_rv1 = rsp1_valid;
    s_res = rsp_result; s_zero = rsp_zero; s_err = rsp_err;
    acc0 = er0; acc1 = er1;
    if (er0 || er1) begin
      op_on  = 1'b1;
      op_cyc = cyc;
      op_id  = g;
      op_a   = g ? req1_a   : req0_a;
      op_b   = g ? req1_b   : req0_b;
      op_ctr = g ? req1_ctr : req0_ctr;
      m_last = g;
      free_at = cyc + 3;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic hold_reset(input int n);
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    model_clear();
    repeat (n) begin
      @(negedge clk);
      check_zero("rst_hold");
      @(posedge clk);
      cyc++;
      #1;
    end
    rst_n   = 1'b1;
    free_at = cyc + 1;
  endtask

  // One operation from a single requester, result compared to hand values
  task automatic run_op(input string name, input bit port, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] c, input logic [W-1:0] xr, input logic xz, input logic xe);
    bit got;
    got = 1'b0;
    req0_valid = !port; req1_valid = port;
    req0_a = a; req0_b = b; req0_ctr = c;
    req1_a = a; req1_b = b; req1_ctr = c;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      got = port ? s_rv1 : s_rv0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_timeout actual=no_rsp expected=rsp", name);
    end else begin
      chk({name, "_res"}, s_res, xr);
      chk({name, "_zero"}, s_zero, xz);
      chk({name, "_err"}, s_err, xe);
      chk({name, "_other_rv"}, port ? s_rv0 : s_rv1, 0);
    end
  endtask

  typedef struct {
    string        name;
    bit           port;
    logic [W-1:0] a, b;
    logic [3:0]   ctr;
    logic [W-1:0] res;
    logic         zero, err;
  } vec_t;

  vec_t tbl[10];
  bit   gq[$];
  int   zcnt, rcnt, vcnt, r1cnt;
  bit   exp_g[4];

  initial begin
    tbl[0] = '{"add",   1'b0, 32'd5,  32'd3,          4'b0000, 32'd8,          1'b0, 1'b0};
    tbl[1] = '{"ill_d", 1'b1, 32'd1,  32'd1,          4'b1101, 32'd0,          1'b1, 1'b1};
    tbl[2] = '{"sll",   1'b0, 32'd4,  32'd1,          4'b0111, 32'd16,         1'b0, 1'b0};
    tbl[3] = '{"sra",   1'b0, 32'd4,  32'h8000_0000,  4'b1010, 32'hF800_0000,  1'b0, 1'b0};
    tbl[4] = '{"subu0", 1'b1, 32'd7,  32'd7,          4'b0001, 32'd0,          1'b1, 1'b0};
    tbl[5] = '{"or0",   1'b0, 32'd0,  32'd0,          4'b0011, 32'd0,          1'b1, 1'b0};
    tbl[6] = '{"and",   1'b1, 32'hF0F0, 32'hFF00,     4'b0010, 32'hF000,       1'b0, 1'b0};
    tbl[7] = '{"ill_f", 1'b0, 32'd3,  32'd4,          4'b1111, 32'd0,          1'b1, 1'b1};
    tbl[8] = '{"srl",   1'b1, 32'd8,  32'h1234_5678,  4'b1000, 32'h0012_3456,  1'b0, 1'b0};
    tbl[9] = '{"subneg",1'b0, 32'd3,  32'd5,          4'b0001, 32'hFFFF_FFFE,  1'b0, 1'b0};

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_ctr = 4'd0;
    req1_a = '0; req1_b = '0; req1_ctr = 4'd0;
    model_clear();
    free_at = 0;
    @(posedge clk); cyc++; #1;
    hold_reset(3);

    for (int i = 0; i < 10; i++)
      run_op(tbl[i].name, tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].ctr, tbl[i].res, tbl[i].zero, tbl[i].err);

    // Contention from a fresh reset: both hold valid continuously
    hold_reset(2);
`ifdef ALU_ARB_RR_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd7; req0_ctr = 4'b0001;
    req1_valid = 1'b1; req1_a = 32'd0; req1_b = 32'd0; req1_ctr = 4'b0011;
    gq.delete();
    zcnt = 0; r1cnt = 0;
    for (int k = 0; k < 13; k++) begin
      step();
      if (s_rdy0 || s_rdy1) gq.push_back(s_rdy1);
      if (s_rdy1) r1cnt++;
      if ((s_rv0 || s_rv1) && s_zero) zcnt++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("cont_grants", gq.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < gq.size()) chk($sformatf("cont_grant%0d", k), gq[k], exp_g[k]);
    chk("cont_zero_rsps", zcnt, 4);
`ifndef ALU_ARB_RR_EN
    chk("cont_rdy1_never", r1cnt, 0);
`endif
    repeat (3) step();

    // Back-to-back on port 0
    rcnt = 0; vcnt = 0;
    req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_ctr = 4'd0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (s_rdy0) rcnt++;
      if (s_rv0) vcnt++;
      if (acc0) begin req0_a = $urandom; req0_b = $urandom; req0_ctr = 4'($urandom_range(0, 11)); end
    end
    req0_valid = 1'b0;
    chk("b2b_ready_count", rcnt, 4);
    chk("b2b_rsp_count", vcnt, 4);
    repeat (3) step();

    // Reset while the operation sits in EXEC
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_ctr = 4'd0;
    for (int k = 0; k < 5 && !acc0; k++) step();
    chk("midrst_accepted", acc0, 1);
    req0_valid = 1'b0;
    hold_reset(2);
    run_op("post_rst", 1'b1, 32'hFF, 32'h0F, 4'b0100, 32'hF0, 1'b0, 1'b0);

    // Randomised traffic; a requester holds its op until accepted
    for (int k = 0; k < 400; k++) begin
      if (!req0_valid || acc0) begin
        req0_valid = $urandom_range(0, 1);
        req0_a = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
        req0_b = $urandom; req0_ctr = 4'($urandom_range(0, 15));
      end
      if (!req1_valid || acc1) begin
        req1_valid = $urandom_range(0, 1);
        req1_a = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
        req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
        req1_ctr = 4'($urandom_range(0, 15));
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of operands and results.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 SHALL have ports req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands (shift amount on a, shifted value on b).
REQ-006 SHALL have ports req0_ctr / req1_ctr  input  4  ALU operation code.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  operation accepted this cycle when valid and ready are both high.
REQ-008 SHALL have ports rsp0_valid / rsp1_valid  output  1  one-cycle result strobe to requester n.
REQ-009 SHALL have ports rsp_result  output  WIDTH, rsp_zero  output  1, rsp_err  output  1; shared, qualified by rsp0_valid or rsp1_valid.
REQ-010 SHALL have ports alu_a, alu_b  output  WIDTH, alu_ctr  output  4  drive the shared ALU.
REQ-011 SHALL have ports alu_result  input  WIDTH, alu_zero  input  1  combinational ALU return.

Function
REQ-012 SHALL implement states IDLE, EXEC, DONE; IDLE->EXEC on acceptance, EXEC->DONE always, DONE->IDLE always.
REQ-013 SHALL assert at most one reqN_ready, only in IDLE, only to the granted valid requester; reqN_ready combinational from state and valids.
REQ-014 SHALL register a, b, ctr and requester id on acceptance; one operation outstanding at a time.
REQ-015 SHALL drive alu_a/alu_b/alu_ctr from the registered operands in EXEC and DONE, and 0/0/4'b0000 in IDLE.
REQ-016 SHALL capture alu_result and alu_zero at the end of EXEC into rsp_result/rsp_zero.
REQ-017 SHALL pulse rspN_valid for exactly the DONE cycle for the requester id captured; latency acceptance edge to rsp valid = 2 cycles; throughput one operation per 3 cycles.
REQ-018 SHALL treat ctr 4'b1100..4'b1111 as illegal: rsp_result=0, rsp_zero=1, rsp_err=1; rsp_err=0 for legal codes.
REQ-019 SHALL hold rsp_result/rsp_zero/rsp_err stable after DONE until the next capture.
REQ-020 SHALL, with only one requester valid in IDLE, grant that requester.
REQ-021 SHALL keep a last-served pointer updated on each acceptance to the accepted id.
REQ-022 SHALL ignore reqN_valid outside IDLE; requester must hold valid and operands until ready.
REQ-023 SHALL not accept in DONE even if a request is pending; acceptance resumes in following IDLE cycle.

Reset
REQ-024 SHALL on rst_n low asynchronously force state IDLE, all ready/valid outputs 0, rsp_result 0, rsp_zero 0, rsp_err 0, alu_a/alu_b/alu_ctr 0, last-served pointer = 1.
REQ-025 SHALL abort any operation in EXEC or DONE on reset with no rspN_valid issued; first post-reset acceptance no earlier than the first clock edge after rst_n rises.

Configuration
REQ-026 SHALL with ALU_ARB_RR_EN defined resolve simultaneous valid requests round-robin: grant the requester not equal to last-served pointer (port 0 wins first tie after reset).
REQ-027 SHALL with ALU_ARB_RR_EN undefined use fixed priority: port 0 always wins simultaneous requests; pointer may be omitted.

Verification
REQ-028 SHALL test single op: req0 a=5 b=3 ctr=0000 accepted at edge T -> alu_ctr=0000 during EXEC, rsp0_valid at T+2 cycles, rsp_result=8, rsp_zero=0, rsp_err=0, rsp1_valid=0.
REQ-029 SHALL test contention: req0 and req1 both valid continuously, req0 subu 7-7, req1 or 0|0 -> RR build: grants 0,1,0,1 with rsp_zero=1 each; non-RR build: port 0 granted every time, req1_ready never high.
REQ-030 SHALL test illegal code: req1 ctr=1101 a=1 b=1 -> rsp1_valid pulse, rsp_result=0, rsp_zero=1, rsp_err=1.
REQ-031 SHALL test shift ordering: req0 ctr=0111 a=4 b=1 -> rsp_result=16; ctr=1010 a=4 b=0x80000000 -> rsp_result=0xF8000000.
REQ-032 SHALL test reset mid-op: assert rst_n low during EXEC -> no rspN_valid, all outputs 0 immediately, next op after release completes normally.
REQ-033 SHALL test back-to-back: req0 valid every cycle -> req0_ready high exactly every third cycle, one rsp0_valid per acceptance.
